// File: rtl/u_count_decode.sv
// u_count_decode: converts a unary bitstream back to binary by counting the
// 1s seen during a window of N = 2^INWD cycles. A start request opens the
// window, the result is held in DONE until the consumer takes it.
module u_count_decode #(
    parameter int INWD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iA,
    input  logic          start,
    input  logic          iReady,
    output logic [INWD:0] oB,
    output logic          oValid,
    output logic          oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Window counter value on the edge that takes the final (Nth) sample.
    localparam logic [INWD:0] LAST_SAMPLE = {1'b0, {INWD{1'b1}}};

    state_t        state;
    state_t        next_state;
    logic [INWD:0] ones_cnt;
    logic [INWD:0] win_cnt;
    logic [INWD:0] ones_inc;
    logic          last_sample;
    logic          clear_cnt;

    assign ones_inc    = ones_cnt + {{INWD{1'b0}}, iA};
    assign last_sample = (state == RUN) && (win_cnt == LAST_SAMPLE);
    assign clear_cnt   = start && ((state == IDLE) || ((state == DONE) && iReady));

    assign oBusy  = (state == RUN);
    assign oValid = (state == DONE);

    // State register; reset drops any partial or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only honoured in IDLE or when a result is being consumed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_sample) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (iReady) begin
                    next_state = start ? RUN : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Ones and window counters: cleared when a window opens, stepped once per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            win_cnt  <= '0;
        end else if (clear_cnt) begin
            ones_cnt <= '0;
            win_cnt  <= '0;
        end else if (state == RUN) begin
            ones_cnt <= ones_inc;
            win_cnt  <= win_cnt + 1'b1;
        end
    end

    // Result register: loaded only on entry to DONE, including the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oB <= '0;
        end else if (last_sample) begin
            oB <= ones_inc;
        end
    end

endmodule

// File: tb/tb_u_count_decode.sv
// tb_u_count_decode: directed test of u_count_decode with INWD=8 (N=256).
module tb_u_count_decode;

    localparam int INWD = 8;
    localparam int N    = 256;

    logic          clk;
    logic          rst_n;
    logic          iA;
    logic          start;
    logic          iReady;
    logic [INWD:0] oB;
    logic          oValid;
    logic          oBusy;

    int assertCount;
    int failCount;
    int busyCycles;
    int validSeen;

    u_count_decode #(.INWD(INWD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iA     (iA),
        .start  (start),
        .iReady (iReady),
        .oB     (oB),
        .oValid (oValid),
        .oBusy  (oBusy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start  = s;
        iA     = a;
        iReady = r;
    endtask

    // One active edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_oB", int'(oB), 0);
        checkOutput("reset_oValid", int'(oValid), 0);
        checkOutput("reset_oBusy", int'(oBusy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // iReady and iA in IDLE do nothing
        applyStimulus(1'b0, 1'b1, 1'b1);
        step();
        checkOutput("idle_ignore_busy", int'(oBusy), 0);
        checkOutput("idle_ignore_valid", int'(oValid), 0);

        // All-ones window, with a stray start mid-run that must not restart it
        applyStimulus(1'b1, 1'b1, 1'b0);
        step();
        busyCycles = int'(oBusy);
        start = 1'b0;
        for (int i = 1; i < N; i++) begin
            start = (i == 100);
            step();
            busyCycles += int'(oBusy);
        end
        start = 1'b0;
        checkOutput("ones_valid_early", int'(oValid), 0);
        checkOutput("ones_busy_cycles", busyCycles, N);
        step();
        checkOutput("ones_valid", int'(oValid), 1);
        checkOutput("ones_oB", int'(oB), 256);
        checkOutput("ones_busy_done", int'(oBusy), 0);

        // Consume: back to IDLE, oB retained
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("consume_valid", int'(oValid), 0);
        checkOutput("consume_oB", int'(oB), 256);

        // All-zeros window
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) step();
        checkOutput("zeros_valid", int'(oValid), 1);
        checkOutput("zeros_oB", int'(oB), 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();

        // Alternating stream, 1 on the first sample
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int j = 1; j <= N; j++) begin
            iA = logic'(j % 2);
            step();
        end
        checkOutput("alt_valid", int'(oValid), 1);
        checkOutput("alt_oB", int'(oB), 128);

        // Held result: iReady low for 10 cycles, start pulsed and ignored
        validSeen = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i == 3) || (i == 4), 1'b1, 1'b0);
            step();
            if (oValid === 1'b1 && oB === 9'd128 && oBusy === 1'b0) validSeen++;
        end
        checkOutput("hold_stable_cycles", validSeen, 10);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();
        checkOutput("hold_release_valid", int'(oValid), 0);
        checkOutput("hold_release_busy", int'(oBusy), 0);
        checkOutput("hold_release_oB", int'(oB), 128);

        // Back-to-back windows with iA=1 throughout
        applyStimulus(1'b1, 1'b1, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) step();
        checkOutput("b2b_first_oB", int'(oB), 256);
        applyStimulus(1'b1, 1'b1, 1'b1);
        step();
        checkOutput("b2b_busy_immediate", int'(oBusy), 1);
        checkOutput("b2b_valid_cleared", int'(oValid), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 1; i < N; i++) step();
        checkOutput("b2b_valid_early", int'(oValid), 0);
        step();
        checkOutput("b2b_second_valid", int'(oValid), 1);
        checkOutput("b2b_second_oB", int'(oB), 256);
        applyStimulus(1'b0, 1'b0, 1'b1);
        step();

        // Asynchronous reset 100 cycles into a window
        applyStimulus(1'b1, 1'b1, 1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_busy", int'(oBusy), 0);
        checkOutput("areset_valid", int'(oValid), 0);
        checkOutput("areset_oB", int'(oB), 0);
        @(negedge clk);
        rst_n = 1'b1;
        validSeen  = 0;
        busyCycles = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            validSeen  += int'(oValid);
            busyCycles += int'(oBusy);
        end
        checkOutput("post_reset_no_valid", validSeen, 0);
        checkOutput("post_reset_no_busy", busyCycles, 0);

        // Fresh window: ten leading ones then zeros
        applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        start = 1'b0;
        for (int j = 1; j <= N; j++) begin
            iA = (j <= 10);
            step();
        end
        checkOutput("partial_valid", int'(oValid), 1);
        checkOutput("partial_oB", int'(oB), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
